// File: rtl/rx_bit_sampler_pkg.sv
// Shared UART Rx constants: legal prescale encodings, default prescale and bit counter width.
package rx_bit_sampler_pkg;

  localparam int unsigned Ps8       = 8;
  localparam int unsigned Ps16      = 16;
  localparam int unsigned Ps32      = 32;
  localparam int unsigned PsDefault = Ps8;

  localparam int unsigned BitCntW   = 4;
  localparam int unsigned BitCntMax = (1 << BitCntW) - 1;

  typedef logic [BitCntW-1:0] bit_cnt_t;

  // Any encoding outside the legal set falls back to the default ratio.
  function automatic int unsigned ps_legalize(input int unsigned ps);
    if (ps == Ps8 || ps == Ps16 || ps == Ps32) begin
      return ps;
    end
    return PsDefault;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (b & c) | (a & c);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for the idle-high serial line; both stages reset to 1.
module bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], async_in};
    end
  end

  assign sync_out = sync_q[1];

endmodule

// File: rtl/rx_bit_sampler.sv
// Oversampling bit sampler: counts edges within each bit period and majority-votes three
// mid-bit samples of the synchronized line.
module rx_bit_sampler
  import rx_bit_sampler_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  samp_en,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  bit_done,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BitCntW-1:0]    bit_cnt
);

  logic rx_s;

  bit_sync u_bit_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (rx_in),
    .sync_out (rx_s)
  );

  logic                  en_q, active_q, active_d;
  logic                  start, run;
  logic [PRESCALE_W-1:0] ps_q, ps_d, ps_lat, ps_eff;
  logic [PRESCALE_W-1:0] half, ps_last, mid0, mid2, vote_pt;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic                  s0_q, s1_q, s2_q, s0_d, s1_d, s2_d;
  logic                  sampled_q, sampled_d;
  bit_cnt_t              bit_cnt_q, bit_cnt_d;

  // Counting only begins on a samp_en rise seen after reset; en_q resets high so a
  // samp_en held through reset does not count as a rise.
  always_comb begin
    start    = samp_en & ~en_q;
    run      = samp_en & (active_q | start);
    active_d = run;
    ps_lat   = PRESCALE_W'(ps_legalize(32'(prescale)));
    ps_eff   = start ? ps_lat : ps_q;
    ps_d     = start ? ps_lat : ps_q;
    half     = ps_eff >> 1;
    ps_last  = ps_eff - PRESCALE_W'(1);
    mid0     = half - PRESCALE_W'(1);
    mid2     = half + PRESCALE_W'(1);
    vote_pt  = half + PRESCALE_W'(2);
  end

  always_comb begin
    bit_done     = run && (edge_q == ps_last);
    sample_valid = run && (edge_q == vote_pt);
  end

  always_comb begin
    edge_d    = '0;
    s0_d      = 1'b0;
    s1_d      = 1'b0;
    s2_d      = 1'b0;
    bit_cnt_d = '0;
    sampled_d = sample_valid ? maj3(s0_q, s1_q, s2_q) : sampled_q;
    if (run) begin
      edge_d    = bit_done ? '0 : edge_q + PRESCALE_W'(1);
      s0_d      = (edge_q == mid0) ? rx_s : s0_q;
      s1_d      = (edge_q == half) ? rx_s : s1_q;
      s2_d      = (edge_q == mid2) ? rx_s : s2_q;
      bit_cnt_d = bit_cnt_q;
      if (bit_done && (bit_cnt_q != bit_cnt_t'(BitCntMax))) begin
        bit_cnt_d = bit_cnt_q + bit_cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b1;
      active_q  <= 1'b0;
      ps_q      <= PRESCALE_W'(PsDefault);
      edge_q    <= '0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      sampled_q <= 1'b1;
      bit_cnt_q <= '0;
    end else begin
      en_q      <= samp_en;
      active_q  <= active_d;
      ps_q      <= ps_d;
      edge_q    <= edge_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      sampled_q <= sampled_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign sampled_bit = sampled_q;
  assign edge_cnt    = edge_q;
  assign bit_cnt     = bit_cnt_q;

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Directed self-checking bench for rx_bit_sampler.
module tb_rx_bit_sampler;

  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          samp_en;
  logic          sampled_bit;
  logic          sample_valid;
  logic          bit_done;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic frame [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;

  rx_bit_sampler #(.PRESCALE_W(PW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_in        (rx_in),
    .prescale     (prescale),
    .samp_en      (samp_en),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid),
    .bit_done     (bit_done),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sampled_bit"}, 32'(sampled_bit), 1);
    check({tag, "_sample_valid"}, 32'(sample_valid), 0);
    check({tag, "_bit_done"}, 32'(bit_done), 0);
    check({tag, "_edge_cnt"}, 32'(edge_cnt), 0);
    check({tag, "_bit_cnt"}, 32'(bit_cnt), 0);
  endtask

  // Walks one bit period starting in its edge_cnt=0 cycle; optional 1-clk inverted pulse on rx_in.
  task automatic run_bit(input int ps, input logic drive, input int exp_cnt, input int glitch);
    for (int k = 0; k < ps; k++) begin
      if (k == 0) rx_in = drive;
      if (k == glitch) rx_in = ~drive;
      if (k == glitch + 1) rx_in = drive;
      #1;
      check("edge_cnt", 32'(edge_cnt), k);
      check("sample_valid", 32'(sample_valid), (k == ps / 2 + 2) ? 1 : 0);
      check("bit_done", 32'(bit_done), (k == ps - 1) ? 1 : 0);
      if (k == ps / 2 + 3) check("sampled_bit", 32'(sampled_bit), 32'(drive));
      step();
    end
    check("bit_cnt", 32'(bit_cnt), exp_cnt);
    check("sampled_bit_hold", 32'(sampled_bit), 32'(drive));
  endtask

  initial begin
    rst_n    = 1'b1;
    samp_en  = 1'b1;
    rx_in    = 1'b1;
    prescale = 6'd8;
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals("por");
    step();
    step();
    rst_n = 1'b1;

    // samp_en held high through reset is not a rise: nothing happens
    repeat (4) step();
    check("idle_edge_cnt", 32'(edge_cnt), 0);
    check("idle_sample_valid", 32'(sample_valid), 0);
    check("idle_bit_cnt", 32'(bit_cnt), 0);

    // prescale 8, line steady low
    samp_en = 1'b0;
    rx_in   = 1'b0;
    repeat (3) step();
    samp_en = 1'b1;
    run_bit(8, 1'b0, 1, -1);
    run_bit(8, 1'b0, 2, -1);

    // reset pulse mid-bit
    repeat (5) step();
    check("pre_rst_edge_cnt", 32'(edge_cnt), 5);
    check("pre_rst_sampled_bit", 32'(sampled_bit), 0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_edge_cnt", 32'(edge_cnt), 0);
    check("post_rst_bit_done", 32'(bit_done), 0);

    // prescale change mid-frame is ignored until samp_en toggles
    samp_en = 1'b0;
    rx_in   = 1'b1;
    repeat (2) step();
    samp_en = 1'b1;
    run_bit(8, 1'b1, 1, -1);
    prescale = 6'd16;
    run_bit(8, 1'b1, 2, -1);
    run_bit(8, 1'b1, 3, -1);
    samp_en = 1'b0;
    step();
    check("off_edge_cnt", 32'(edge_cnt), 0);
    check("off_bit_cnt", 32'(bit_cnt), 0);

    // prescale 16 with single-clock low glitches
    samp_en = 1'b1;
    run_bit(16, 1'b1, 1, 8);
    run_bit(16, 1'b1, 2, 6);

    // abort mid-bit before the vote point
    rx_in = 1'b0;
    repeat (9) step();
    check("abort_edge_cnt", 32'(edge_cnt), 9);
    samp_en = 1'b0;
    #1;
    check("abort_sample_valid", 32'(sample_valid), 0);
    check("abort_bit_done", 32'(bit_done), 0);
    step();
    check("abort_edge_clr", 32'(edge_cnt), 0);
    check("abort_sampled_bit", 32'(sampled_bit), 1);
    check("abort_bit_cnt", 32'(bit_cnt), 0);
    repeat (3) begin
      step();
      check("abort_quiet", 32'({sample_valid, bit_done}), 0);
    end
    samp_en = 1'b1;
    run_bit(16, 1'b0, 1, -1);

    // illegal prescale behaves as 8
    samp_en  = 1'b0;
    prescale = 6'd5;
    repeat (2) step();
    samp_en = 1'b1;
    run_bit(8, 1'b1, 1, -1);
    run_bit(8, 1'b0, 2, -1);

    // prescale 32, 11-bit frame then saturation of bit_cnt
    samp_en  = 1'b0;
    prescale = 6'd32;
    repeat (2) step();
    samp_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic b;
      b = (i < 11) ? frame[i] : 1'b1;
      run_bit(32, b, (i + 1 > 15) ? 15 : i + 1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rx_bit_sampler.md
RX_BIT_SAMPLER -- requirements
Module: rx_bit_sampler

Interface
REQ-001 Parameter PRESCALE_W, default 6, width of the prescale input and of the edge counter.
REQ-002 clk  input  1  single rising-edge clock, oversampling rate (prescale x baud).
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 rx_in  input  1  raw serial line, asynchronous to clk, idle high.
REQ-005 prescale  input  PRESCALE_W  oversampling ratio; legal values are 8, 16 and 32.
REQ-006 samp_en  input  1  enable from the Rx FSM; high for the whole frame.
REQ-007 sampled_bit  output  1  majority-voted bit value, registered; feeds start/parity/stop checks and the deserializer.
REQ-008 sample_valid  output  1  one-cycle strobe; sampled_bit is updated in this cycle.
REQ-009 bit_done  output  1  one-cycle strobe on the last oversample edge of each bit period.
REQ-010 edge_cnt  output  PRESCALE_W  current oversample edge index within the bit.
REQ-011 bit_cnt  output  4  number of completed bit periods since samp_en rose.

Function
REQ-012 rx_in shall pass through a 2-flop synchronizer (rx_s) before any use; both flops reset to 1.
REQ-013 On the samp_en 0->1 cycle, prescale shall be latched into ps_q; a change of prescale mid-frame shall have no effect.
REQ-014 A latched prescale other than 8/16/32 shall be treated as 8.
REQ-015 While samp_en=1, edge_cnt shall increment by 1 per clk from 0 to ps_q-1, then wrap to 0.
REQ-016 bit_done shall be 1 exactly when samp_en=1 and edge_cnt=ps_q-1.
REQ-017 bit_cnt shall increment on each bit_done and saturate at 15.
REQ-018 rx_s shall be captured into s0, s1 and s2 at edge_cnt = ps_q/2-1, ps_q/2 and ps_q/2+1 respectively.
REQ-019 In the cycle where edge_cnt=ps_q/2+2, sampled_bit shall take the majority of (s0, s1, s2), and sample_valid shall be 1.
REQ-020 sampled_bit shall hold its value between sample_valid strobes and while samp_en=0.
REQ-021 While samp_en=0, edge_cnt, bit_cnt, s0, s1 and s2 shall clear synchronously to 0, and sample_valid and bit_done shall be 0.
REQ-022 samp_en falling mid-bit shall abort the bit: no sample_valid strobe and no bit_done strobe for that bit; on the next rise, counting restarts at edge_cnt=0.
REQ-023 Latency: an rx_in change reaches a sample register 2 clk later.
REQ-024 Sampling uses s0, s1 and s2 with no other filtering; a 1-edge glitch at mid-bit shall not change sampled_bit.

Reset
REQ-025 Asserting rst_n=0 at any time, including mid-frame, shall immediately set:
- sampled_bit=1, sample_valid=0, bit_done=0
- edge_cnt=0, bit_cnt=0
- ps_q=8, s0=s1=s2=0, synchronizer flops=1
REQ-026 After rst_n deasserts, the block shall take no action until the next samp_en rising edge.

Structure
REQ-027 The legal prescale encodings (8/16/32), the default prescale (8) and the bit_cnt width (4) shall live in the shared UART Rx package, which the FSM and the checker blocks also use.
REQ-028 The 2-flop synchronizer shall be a separate sub-module, bit_sync, with reset value 1; all other logic stays flat.

Verification
REQ-029 Bench shall cover:
- prescale=8, samp_en=1, rx_in=0 steady -> sample_valid at edge_cnt=6, sampled_bit=0, bit_done at edge_cnt=7, bit_cnt=1.
- prescale=16, rx_in=1 with a 1-clk low pulse at edge_cnt=8 -> sampled_bit=1, no change.
- prescale=32, 11-bit frame 0_10110011_1_1 -> sampled_bit sequence matches the frame, and bit_cnt=11 after the last bit_done.
- prescale changed from 8 to 16 mid-frame -> bit period stays 8 clk until samp_en toggles.
- prescale=5 -> behaves as 8.
- rst_n pulsed low at edge_cnt=5 with sampled_bit=0 -> all outputs at reset values in the same cycle, sampled_bit=1.
